control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired multi-cycle control unit for the 16-bit accumulator processor datapath.
- Runs the fetch/decode/execute loop on 6-bit opcodes from the IR path.
- Each cycle drives A-bus source select, one-hot C-bus load enables, ALU op, increment strobes and memory read/write.
- Sits beside the datapath inside the processor top level and replaces ad-hoc control decoding.

Parameters:
- MEM_WAIT, 1, extra wait cycles after a memory read before data is valid (0..3).
- OPW, 6, opcode width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ir_in  in  6  opcode field of the word on the memory data path; captured via ldir.
- z_flag  in  1  ALU zero flag from the datapath.
- a_bus_sel  out  4  A-bus source: 0 none, 1 PC, 2 AC, 3 RA, 4 RB, 5 RC, 6 MDR.
- c_bus_ld  out  10  one-hot load enables: b0 MAR, b1 MDR, b2 PC, b3 IR, b4 AC, b5 RA, b6 RB, b7 RC, b8..b9 reserved (always 0).
- alu_op  out  3  0 PASS, 1 ADD, 2 SUB, 3 CLR.
- ldir  out  1  load IR.
- pc_inc, ac_inc, ra_inc, rb_inc, rc_inc  out  1 each  single-cycle increment strobes.
- mem_read  out  1  memory read at address MAR.
- mem_write  out  1  memory write of MDR at address MAR.
- step  out  6  current state code, for debug and trace.
- halted  out  1  high in HALT.

Behaviour:
- Reset: async, rst_n low forces state FETCH1, the wait counter to 0 and every output to 0, including mid-instruction. Outputs are registered.
- States: FETCH1, FETCH2, FETCH3, DECODE, EX1, EX2, EX3, HALT.
- FETCH1: a_bus_sel=PC, c_bus_ld[MAR]=1.
- FETCH2: mem_read=1, c_bus_ld[MDR]=1. Stays in FETCH2 for MEM_WAIT additional cycles.
- FETCH3: ldir=1, pc_inc=1.
- DECODE: latches the opcode and z_flag, then dispatches.
- Base instruction latency is 4 cycles (MEM_WAIT=0), plus one cycle per EX state used.
- Opcodes:
  - 000000 NOP: DECODE goes straight to FETCH1.
  - 000001 END: goes to HALT. HALT holds, halted=1, all strobes 0, until reset.
  - 000010 CLAC: EX1 alu_op=CLR, c_bus_ld[AC].
  - 000011 INCAC: EX1 ac_inc.
  - 000100 ADD / 000101 SUB: EX1 a_bus_sel=RA, alu_op ADD/SUB, c_bus_ld[AC].
  - 000110 JUMP (address in the next word): EX1 a_bus_sel=PC, c_bus_ld[MAR]. EX2 mem_read, c_bus_ld[MDR], honouring the MEM_WAIT stall. EX3 a_bus_sel=MDR, c_bus_ld[PC].
  - 000111 JPNZ: if the latched z_flag=0, runs the JUMP sequence. Otherwise EX1 pc_inc (skips the address word), then FETCH1.
  - 001000 STAC: EX1 a_bus_sel=AC, c_bus_ld[MDR]. EX2 mem_write (MAR unchanged from fetch).
  - 01xsss MVR: EX1 a_bus_sel=sss (1..6), alu_op PASS, c_bus_ld[AC].
  - 10xddd MVAC: EX1 a_bus_sel=AC, c_bus_ld[4+ddd] for ddd in 1..3 (RA/RB/RC).
  - 11xddd INCR: EX1 pulses ra_inc, rb_inc or rc_inc for ddd=1..3.
- Every instruction's last EX state returns to FETCH1.
- At most one c_bus_ld bit is high per cycle; mem_read and mem_write are never both high.
- Illegal opcode (unlisted, or sss/ddd out of range): behaves as NOP unless the optional feature is enabled.
- step encoding: FETCH1=0, FETCH2=1, FETCH3=2, DECODE=3, EX1=4, EX2=5, EX3=6, HALT=63.

Optional Feature:
- Macro CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode goes DECODE to HALT and raises an extra output illegal_op=1, held until reset.
- Undefined: the illegal_op port is absent and illegal opcodes execute as NOP.

Decomposition:
- Shared package ctrl_pkg holds opcode constants, the A-bus source codes, C-bus bit indices, ALU op codes and state codes, for reuse by the datapath and benches.
- One sub-module, ctrl_decoder: combinational mapping of (state, opcode, latched z) to next state and output vector. The top keeps the state register, wait counter and output registers.

Test Plan:
- Reset mid-EX2 of JUMP (rst_n low 10 ns) -> all outputs 0 immediately; first post-reset cycle is FETCH1 with a_bus_sel=1, c_bus_ld=0000000001.
- NOP then INCAC, MEM_WAIT=1 -> NOP takes 5 cycles; INCAC shows exactly one ac_inc pulse, in cycle 6 of its instruction.
- JPNZ with z_flag=1 -> a single pc_inc in EX1, no c_bus_ld[PC]. With z_flag=0 -> EX3 a_bus_sel=6, c_bus_ld=0000000100.
- MVR 010011 then MVAC 100010 -> a_bus_sel=3 with c_bus_ld[4]; then a_bus_sel=2 with c_bus_ld[6].
- STAC -> EX1 c_bus_ld[MDR], EX2 mem_write=1 for exactly one cycle; mem_read=0 throughout.
- END -> halted=1, step=63, all strobes 0 for 20 cycles. Opcode 111111: NOP without the feature; with CTRL_ILLEGAL_TRAP_EN, HALT plus illegal_op=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control definitions for the accumulator processor: opcodes, A-bus
// source codes, C-bus load-enable bit positions, ALU op codes, sequencer
// state codes and the registered control-word layout.
package ctrl_pkg;

    localparam int OPW_C = 6;
    localparam int CBW   = 10;

    localparam logic [5:0] OP_NOP   = 6'b000000;
    localparam logic [5:0] OP_END   = 6'b000001;
    localparam logic [5:0] OP_CLAC  = 6'b000010;
    localparam logic [5:0] OP_INCAC = 6'b000011;
    localparam logic [5:0] OP_ADD   = 6'b000100;
    localparam logic [5:0] OP_SUB   = 6'b000101;
    localparam logic [5:0] OP_JUMP  = 6'b000110;
    localparam logic [5:0] OP_JPNZ  = 6'b000111;
    localparam logic [5:0] OP_STAC  = 6'b001000;

    localparam logic [3:0] ASEL_NONE = 4'd0;
    localparam logic [3:0] ASEL_PC   = 4'd1;
    localparam logic [3:0] ASEL_AC   = 4'd2;
    localparam logic [3:0] ASEL_RA   = 4'd3;
    localparam logic [3:0] ASEL_RB   = 4'd4;
    localparam logic [3:0] ASEL_RC   = 4'd5;
    localparam logic [3:0] ASEL_MDR  = 4'd6;

    localparam int CB_MAR = 0;
    localparam int CB_MDR = 1;
    localparam int CB_PC  = 2;
    localparam int CB_IR  = 3;
    localparam int CB_AC  = 4;
    localparam int CB_RA  = 5;
    localparam int CB_RB  = 6;
    localparam int CB_RC  = 7;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_CLR  = 3'd3;

    typedef enum logic [5:0] {
        ST_FETCH1 = 6'd0,
        ST_FETCH2 = 6'd1,
        ST_FETCH3 = 6'd2,
        ST_DECODE = 6'd3,
        ST_EX1    = 6'd4,
        ST_EX2    = 6'd5,
        ST_EX3    = 6'd6,
        ST_HALT   = 6'd63
    } state_t;

    typedef struct packed {
        logic [3:0]     a_bus_sel;
        logic [CBW-1:0] c_bus_ld;
        logic [2:0]     alu_op;
        logic           ldir;
        logic           pc_inc;
        logic           ac_inc;
        logic           ra_inc;
        logic           rb_inc;
        logic           rc_inc;
        logic           mem_read;
        logic           mem_write;
        logic           halted;
    } ctrl_out_t;

    // True for every opcode with a defined meaning, including register fields in range.
    function automatic logic op_is_legal(input logic [5:0] op);
        logic ok;
        case (op[5:4])
            2'b00:   ok = (op <= OP_STAC);
            2'b01:   ok = (op[2:0] >= 3'd1) && (op[2:0] <= 3'd6);
            default: ok = (op[2:0] >= 3'd1) && (op[2:0] <= 3'd3);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational decode of (state, opcode, latched zero flag) into the next
// state and the control word for the current state.
// Build option: CTRL_ILLEGAL_TRAP_EN adds the o_trap request for illegal opcodes.
module ctrl_decoder
    import ctrl_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_op,
    input  logic       i_z,
    input  logic       i_wait_done,
    output state_t     o_next,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output logic       o_trap,
`endif
    output ctrl_out_t  o_out
);

    logic w_jump;
    logic w_legal;

    assign w_jump  = (i_op == OP_JUMP) || ((i_op == OP_JPNZ) && !i_z);
    assign w_legal = op_is_legal(i_op);

    // Next-state and per-state control word, defaults first.
    always_comb begin
        o_next = ST_FETCH1;
        o_out  = '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        o_trap = 1'b0;
`endif
        case (i_state)
            ST_FETCH1: begin
                o_out.a_bus_sel        = ASEL_PC;
                o_out.c_bus_ld[CB_MAR] = 1'b1;
                o_next                 = ST_FETCH2;
            end
            ST_FETCH2: begin
                o_out.mem_read         = 1'b1;
                o_out.c_bus_ld[CB_MDR] = 1'b1;
                o_next                 = i_wait_done ? ST_FETCH3 : ST_FETCH2;
            end
            ST_FETCH3: begin
                o_out.ldir   = 1'b1;
                o_out.pc_inc = 1'b1;
                o_next       = ST_DECODE;
            end
            ST_DECODE: begin
                if (i_op == OP_NOP) begin
                    o_next = ST_FETCH1;
                end else if (i_op == OP_END) begin
                    o_next = ST_HALT;
                end else if (w_legal) begin
                    o_next = ST_EX1;
                end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    o_next = ST_HALT;
                    o_trap = 1'b1;
`else
                    o_next = ST_FETCH1;
`endif
                end
            end
            ST_EX1: begin
                if (w_jump) begin
                    o_out.a_bus_sel        = ASEL_PC;
                    o_out.c_bus_ld[CB_MAR] = 1'b1;
                    o_next                 = ST_EX2;
                end else if (i_op == OP_JPNZ) begin
                    // Zero set: step over the address word.
                    o_out.pc_inc = 1'b1;
                end else if (i_op == OP_STAC) begin
                    o_out.a_bus_sel        = ASEL_AC;
                    o_out.c_bus_ld[CB_MDR] = 1'b1;
                    o_next                 = ST_EX2;
                end else if (i_op == OP_CLAC) begin
                    o_out.alu_op          = ALU_CLR;
                    o_out.c_bus_ld[CB_AC] = 1'b1;
                end else if (i_op == OP_INCAC) begin
                    o_out.ac_inc = 1'b1;
                end else if ((i_op == OP_ADD) || (i_op == OP_SUB)) begin
                    o_out.a_bus_sel       = ASEL_RA;
                    o_out.alu_op          = (i_op == OP_ADD) ? ALU_ADD : ALU_SUB;
                    o_out.c_bus_ld[CB_AC] = 1'b1;
                end else if (w_legal && (i_op[5:4] == 2'b01)) begin
                    o_out.a_bus_sel       = {1'b0, i_op[2:0]};
                    o_out.alu_op          = ALU_PASS;
                    o_out.c_bus_ld[CB_AC] = 1'b1;
                end else if (w_legal && (i_op[5:4] == 2'b10)) begin
                    o_out.a_bus_sel = ASEL_AC;
                    o_out.c_bus_ld  = 10'b00_0001_0000 << i_op[1:0];
                end else if (w_legal && (i_op[5:4] == 2'b11)) begin
                    o_out.ra_inc = (i_op[1:0] == 2'd1);
                    o_out.rb_inc = (i_op[1:0] == 2'd2);
                    o_out.rc_inc = (i_op[1:0] == 2'd3);
                end
            end
            ST_EX2: begin
                if (w_jump) begin
                    o_out.mem_read         = 1'b1;
                    o_out.c_bus_ld[CB_MDR] = 1'b1;
                    o_next                 = i_wait_done ? ST_EX3 : ST_EX2;
                end else if (i_op == OP_STAC) begin
                    o_out.mem_write = 1'b1;
                end
            end
            ST_EX3: begin
                o_out.a_bus_sel       = ASEL_MDR;
                o_out.c_bus_ld[CB_PC] = 1'b1;
            end
            ST_HALT: begin
                o_out.halted = 1'b1;
                o_next       = ST_HALT;
            end
            default: o_next = ST_FETCH1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit: state register, memory wait counter,
// opcode/zero latch and registered control outputs. Outputs show the control
// word of the state the sequencer has just left, so every strobe is a clean
// register output.
// Build option: CTRL_ILLEGAL_TRAP_EN halts on illegal opcodes and adds illegal_op.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 1,
    parameter int OPW      = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] ir_in,
    input  logic           z_flag,
    output logic [3:0]     a_bus_sel,
    output logic [9:0]     c_bus_ld,
    output logic [2:0]     alu_op,
    output logic           ldir,
    output logic           pc_inc,
    output logic           ac_inc,
    output logic           ra_inc,
    output logic           rb_inc,
    output logic           rc_inc,
    output logic           mem_read,
    output logic           mem_write,
    output logic [5:0]     step,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output logic           illegal_op,
`endif
    output logic           halted
);

    state_t         r_state;
    state_t         r_step;
    logic [1:0]     r_wait;
    logic [OPW-1:0] r_op;
    logic           r_z;
    ctrl_out_t      r_out;

    state_t         w_next;
    ctrl_out_t      w_out;
    logic [OPW-1:0] w_op;
    logic           w_z;
    logic           w_wait_done;
    logic           w_waiting;

    // DECODE dispatches on the live opcode/flag; later EX states use the latched copies.
    assign w_op        = (r_state == ST_DECODE) ? ir_in  : r_op;
    assign w_z         = (r_state == ST_DECODE) ? z_flag : r_z;
    assign w_wait_done = (r_wait == 2'(MEM_WAIT));
    assign w_waiting   = ((r_state == ST_FETCH2) || (r_state == ST_EX2)) && (w_next == r_state);

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic r_trap;
    logic w_trap;
`endif

    ctrl_decoder u_dec (
        .i_state     (r_state),
        .i_op        (w_op),
        .i_z         (w_z),
        .i_wait_done (w_wait_done),
        .o_next      (w_next),
`ifdef CTRL_ILLEGAL_TRAP_EN
        .o_trap      (w_trap),
`endif
        .o_out       (w_out)
    );

    // State register, wait counter and opcode/zero latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH1;
            r_wait  <= 2'd0;
            r_op    <= '0;
            r_z     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_waiting ? (r_wait + 2'd1) : 2'd0;
            if (r_state == ST_DECODE) begin
                r_op <= ir_in;
                r_z  <= z_flag;
            end
        end
    end

    // Registered control word and trace code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out  <= '0;
            r_step <= ST_FETCH1;
        end else begin
            r_out  <= w_out;
            r_step <= r_state;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    // Sticky illegal-opcode flag; the output copy lines up with halted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trap     <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            if (w_trap) r_trap <= 1'b1;
            illegal_op <= r_trap;
        end
    end
`endif

    assign a_bus_sel = r_out.a_bus_sel;
    assign c_bus_ld  = r_out.c_bus_ld;
    assign alu_op    = r_out.alu_op;
    assign ldir      = r_out.ldir;
    assign pc_inc    = r_out.pc_inc;
    assign ac_inc    = r_out.ac_inc;
    assign ra_inc    = r_out.ra_inc;
    assign rb_inc    = r_out.rb_inc;
    assign rc_inc    = r_out.rc_inc;
    assign mem_read  = r_out.mem_read;
    assign mem_write = r_out.mem_write;
    assign halted    = r_out.halted;
    assign step      = r_step;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each instruction pushes its expected
// per-cycle control words, which are popped and compared one per clock.
module tb_control_sequencer;

    localparam int MW = 1;

    typedef logic [32:0] vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] ir_in;
    logic       z_flag;
    logic [3:0] a_bus_sel;
    logic [9:0] c_bus_ld;
    logic [2:0] alu_op;
    logic       ldir, pc_inc, ac_inc, ra_inc, rb_inc, rc_inc;
    logic       mem_read, mem_write, halted;
    logic [5:0] step;
    logic       ill_bit;

    int checks   = 0;
    int failures = 0;
    vec_t exp_q[$];

    control_sequencer #(.MEM_WAIT(MW), .OPW(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ir_in      (ir_in),
        .z_flag     (z_flag),
        .a_bus_sel  (a_bus_sel),
        .c_bus_ld   (c_bus_ld),
        .alu_op     (alu_op),
        .ldir       (ldir),
        .pc_inc     (pc_inc),
        .ac_inc     (ac_inc),
        .ra_inc     (ra_inc),
        .rb_inc     (rb_inc),
        .rc_inc     (rc_inc),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .step       (step),
`ifdef CTRL_ILLEGAL_TRAP_EN
        .illegal_op (ill_bit),
`endif
        .halted     (halted)
    );

`ifndef CTRL_ILLEGAL_TRAP_EN
    assign ill_bit = 1'b0;
`endif

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_vec(input string tag, input vec_t act, input vec_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // Layout: {illegal, a_bus_sel, c_bus_ld, alu_op, strobes[7:0], halted, step}
    // strobes = {ldir, pc_inc, ac_inc, ra_inc, rb_inc, rc_inc, mem_read, mem_write}
    function automatic vec_t mk(input logic [3:0] a, input logic [9:0] ld, input logic [2:0] alu,
                                input logic [7:0] s, input logic h, input logic [5:0] st,
                                input logic ill);
        return {ill, a, ld, alu, s, h, st};
    endfunction

    function automatic vec_t sample();
        return {ill_bit, a_bus_sel, c_bus_ld, alu_op,
                ldir, pc_inc, ac_inc, ra_inc, rb_inc, rc_inc, mem_read, mem_write,
                halted, step};
    endfunction

    // Expected cycle list for one instruction, straight from the opcode table.
    task automatic push_instr(input logic [5:0] op, input logic z);
        logic [2:0] f;
        f = op[2:0];
        ir_in  = op;
        z_flag = z;
        exp_q.push_back(mk(4'd1, 10'd1, 3'd0, 8'h00, 1'b0, 6'd0, 1'b0));
        for (int i = 0; i <= MW; i++)
            exp_q.push_back(mk(4'd0, 10'd2, 3'd0, 8'b0000_0010, 1'b0, 6'd1, 1'b0));
        exp_q.push_back(mk(4'd0, 10'd0, 3'd0, 8'b1100_0000, 1'b0, 6'd2, 1'b0));
        exp_q.push_back(mk(4'd0, 10'd0, 3'd0, 8'h00, 1'b0, 6'd3, 1'b0));
        if (op == 6'd0) begin
        end else if (op == 6'd1) begin
            for (int i = 0; i < 20; i++)
                exp_q.push_back(mk(4'd0, 10'd0, 3'd0, 8'h00, 1'b1, 6'd63, 1'b0));
        end else if (op == 6'd2) begin
            exp_q.push_back(mk(4'd0, 10'd16, 3'd3, 8'h00, 1'b0, 6'd4, 1'b0));
        end else if (op == 6'd3) begin
            exp_q.push_back(mk(4'd0, 10'd0, 3'd0, 8'b0010_0000, 1'b0, 6'd4, 1'b0));
        end else if (op == 6'd4 || op == 6'd5) begin
            exp_q.push_back(mk(4'd3, 10'd16, (op == 6'd4) ? 3'd1 : 3'd2, 8'h00, 1'b0, 6'd4, 1'b0));
        end else if (op == 6'd6 || (op == 6'd7 && !z)) begin
            exp_q.push_back(mk(4'd1, 10'd1, 3'd0, 8'h00, 1'b0, 6'd4, 1'b0));
            for (int i = 0; i <= MW; i++)
                exp_q.push_back(mk(4'd0, 10'd2, 3'd0, 8'b0000_0010, 1'b0, 6'd5, 1'b0));
            exp_q.push_back(mk(4'd6, 10'd4, 3'd0, 8'h00, 1'b0, 6'd6, 1'b0));
        end else if (op == 6'd7) begin
            exp_q.push_back(mk(4'd0, 10'd0, 3'd0, 8'b0100_0000, 1'b0, 6'd4, 1'b0));
        end else if (op == 6'd8) begin
            exp_q.push_back(mk(4'd2, 10'd2, 3'd0, 8'h00, 1'b0, 6'd4, 1'b0));
            exp_q.push_back(mk(4'd0, 10'd0, 3'd0, 8'b0000_0001, 1'b0, 6'd5, 1'b0));
        end else if (op[5:4] == 2'b01 && f >= 3'd1 && f <= 3'd6) begin
            exp_q.push_back(mk({1'b0, f}, 10'd16, 3'd0, 8'h00, 1'b0, 6'd4, 1'b0));
        end else if (op[5:4] == 2'b10 && f >= 3'd1 && f <= 3'd3) begin
            exp_q.push_back(mk(4'd2, (f == 3'd1) ? 10'd32 : (f == 3'd2) ? 10'd64 : 10'd128,
                               3'd0, 8'h00, 1'b0, 6'd4, 1'b0));
        end else if (op[5:4] == 2'b11 && f >= 3'd1 && f <= 3'd3) begin
            exp_q.push_back(mk(4'd0, 10'd0, 3'd0,
                               (f == 3'd1) ? 8'b0001_0000 : (f == 3'd2) ? 8'b0000_1000 : 8'b0000_0100,
                               1'b0, 6'd4, 1'b0));
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            for (int i = 0; i < 20; i++)
                exp_q.push_back(mk(4'd0, 10'd0, 3'd0, 8'h00, 1'b1, 6'd63, 1'b1));
`endif
        end
    endtask

    // Pop and compare up to n expected cycles (n < 0: until the queue is empty).
    task automatic drain(input string name, input int n);
        int k;
        k = 0;
        while (exp_q.size() > 0 && (n < 0 || k < n)) begin
            vec_t e;
            @(negedge clk);
            e = exp_q.pop_front();
            check_vec($sformatf("%s_c%0d", name, k + 1), sample(), e);
            k++;
        end
    endtask

    task automatic run_instr(input string name, input logic [5:0] op, input logic z);
        push_instr(op, z);
        drain(name, -1);
    endtask

    // Async reset 2 ns after a sample edge, held 10 ns; outputs must clear at once.
    task automatic pulse_reset(input string name);
        #2 rst_n = 1'b0;
        #1 check_vec(name, sample(), '0);
        #9 rst_n = 1'b1;
        exp_q.delete();
    endtask

    logic [5:0] legal_tab [15] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08,
                                   6'h11, 6'h16, 6'h19, 6'h22, 6'h23, 6'h31, 6'h33};

    initial begin
        rst_n  = 1'b0;
        ir_in  = 6'd0;
        z_flag = 1'b0;
        repeat (2) @(negedge clk);
        check_vec("reset", sample(), '0);
        rst_n = 1'b1;

        run_instr("nop", 6'b000000, 1'b0);
        run_instr("incac", 6'b000011, 1'b0);
        run_instr("jpnz_z1", 6'b000111, 1'b1);
        run_instr("jpnz_z0", 6'b000111, 1'b0);
        run_instr("jump", 6'b000110, 1'b1);
        run_instr("mvr_ra", 6'b010011, 1'b0);
        run_instr("mvac_rb", 6'b100010, 1'b0);
        run_instr("clac", 6'b000010, 1'b0);
        run_instr("add", 6'b000100, 1'b0);
        run_instr("sub", 6'b000101, 1'b1);
        run_instr("stac", 6'b001000, 1'b0);
        run_instr("mvr_mdr", 6'b010110, 1'b0);
        run_instr("incr_ra", 6'b110001, 1'b0);
        run_instr("incr_rb", 6'b110010, 1'b0);
        run_instr("incr_rc", 6'b111011, 1'b0);
        run_instr("mvac_rc", 6'b101011, 1'b0);

        for (int i = 0; i < 10; i++) begin
            logic [5:0] op;
            op = legal_tab[$urandom_range(0, 14)];
            run_instr($sformatf("rnd%0d_op%02h", i, op), op, 1'($urandom_range(0, 1)));
        end

        // Abort a JUMP in its first EX2 cycle.
        push_instr(6'b000110, 1'b0);
        drain("jump_pre", 6 + MW);
        pulse_reset("rst_mid_ex2");
        run_instr("post_rst", 6'b000000, 1'b0);

        run_instr("mvac_bad", 6'b100000, 1'b0);
        run_instr("illegal", 6'b111111, 1'b0);
`ifndef CTRL_ILLEGAL_TRAP_EN
        run_instr("end", 6'b000001, 1'b0);
`endif
        pulse_reset("rst_from_halt");
        run_instr("after_halt", 6'b000011, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
